// File: rtl/pu_feeder_pkg.sv
// Shared types and constants for the process_unit operand feeder.
// The optional zero-pair skip is controlled by PU_FEEDER_ZERO_SKIP_EN in pu_operand_feeder.
package pu_feeder_pkg;

  localparam int DATA_W        = 16;
  localparam int ADDR_W        = 4;
  localparam int CNT_W         = 8;
  localparam int FETCH_CYC_DEF = 1;
  localparam int GAP_CYC_DEF   = 6;
  localparam int RES_WAIT_DEF  = 2;
  // Clock cycles one issued pair occupies: setup + fetch strobe + idle gap.
  localparam int PAIR_CYC      = 1 + FETCH_CYC_DEF + GAP_CYC_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_FETCH,
    S_GAP,
    S_FINISH,
    S_WAIT,
    S_DONE
  } state_e;

endpackage

// File: rtl/pu_operand_buf.sv
// Operand-pair register file: one synchronous write port, one asynchronous read port.
module pu_operand_buf #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage arrays carry no reset; their contents are only read after a write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pu_operand_feeder.sv
// Issues buffered (a, b) pairs to a process_unit, then strobes finish and captures the sum.
// Define PU_FEEDER_ZERO_SKIP_EN to skip pairs with a zero operand and expose skip_cnt.
module pu_operand_feeder
  import pu_feeder_pkg::*;
#(
  parameter int DEPTH     = 1 << ADDR_W,
  parameter int FETCH_CYC = FETCH_CYC_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF,
  parameter int RES_WAIT  = RES_WAIT_DEF
) (
  input  logic              m_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_a,
  input  logic [DATA_W-1:0] wr_b,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic [DATA_W-1:0] pu_a,
  output logic [DATA_W-1:0] pu_b,
  output logic              pu_fetch_enable,
  output logic              pu_finish_enable,
  input  logic [DATA_W-1:0] pu_sum,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done
`ifdef PU_FEEDER_ZERO_SKIP_EN
  ,
  output logic [ADDR_W:0]   skip_cnt
`endif
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(DEPTH);
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] RES_LAST   = CNT_W'(RES_WAIT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    idx_q, idx_d, len_q, len_d, idx_inc;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [DATA_W-1:0]   rd_a, rd_b;
  logic                more;
`ifdef PU_FEEDER_ZERO_SKIP_EN
  logic [LEN_W-1:0]    skip_q, skip_d;
`endif

  pu_operand_buf #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (2 * DATA_W)
  ) u_buf (
    .clk     (m_clk),
    .wr_en   (wr_en && (state_q == S_IDLE)),
    .wr_addr (wr_addr),
    .wr_data ({wr_a, wr_b}),
    .rd_addr (idx_q[ADDR_W-1:0]),
    .rd_data ({rd_a, rd_b})
  );

  assign idx_inc = idx_q + 1'b1;
  assign more    = idx_inc < len_q;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    idx_d   = idx_q;
    len_d   = len_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
`ifdef PU_FEEDER_ZERO_SKIP_EN
    skip_d  = skip_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = (len > LEN_MAX) ? LEN_MAX : len;
          idx_d   = '0;
          state_d = (len == '0) ? S_FINISH : S_SETUP;
`ifdef PU_FEEDER_ZERO_SKIP_EN
          skip_d  = '0;
`endif
        end
      end
      S_SETUP: begin
`ifdef PU_FEEDER_ZERO_SKIP_EN
        if (rd_a == '0 || rd_b == '0) begin
          idx_d   = idx_inc;
          skip_d  = skip_q + 1'b1;
          state_d = more ? S_SETUP : S_FINISH;
        end else
`endif
        begin
          a_d     = rd_a;
          b_d     = rd_b;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (cnt_q != FETCH_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (GAP_CYC == 0) begin
          idx_d   = idx_inc;
          state_d = more ? S_SETUP : S_FINISH;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q != GAP_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          idx_d   = idx_inc;
          state_d = more ? S_SETUP : S_FINISH;
        end
      end
      S_FINISH: state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q != RES_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          res_d   = pu_sum;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge m_clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
`ifdef PU_FEEDER_ZERO_SKIP_EN
      skip_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
`ifdef PU_FEEDER_ZERO_SKIP_EN
      skip_q  <= skip_d;
`endif
    end
  end

  // Operands appear straight from the buffer during setup, then stay registered.
  assign pu_a             = (state_q == S_SETUP) ? rd_a : a_q;
  assign pu_b             = (state_q == S_SETUP) ? rd_b : b_q;
  assign pu_fetch_enable  = (state_q == S_FETCH);
  assign pu_finish_enable = (state_q == S_FINISH);
  assign busy             = !(state_q == S_IDLE || state_q == S_DONE);
  assign done             = (state_q == S_DONE);
  assign result           = res_q;
`ifdef PU_FEEDER_ZERO_SKIP_EN
  assign skip_cnt         = skip_q;
`endif

endmodule
